// File: rtl/tug_referee.sv
// Tug-of-war round/match referee: key edge pulses, point detection, field hold and scoring.
// Define TUG_AUTO_RESTART_EN to restart the match RESTART_CYCLES after a win.
module tug_referee #(
  parameter int WIN_SCORE      = 7,
  parameter int SCORE_W        = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int RESTART_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               keyL,
  input  logic               keyR,
  input  logic               edgeL,
  input  logic               edgeR,
  output logic               pressL,
  output logic               pressR,
  output logic               fieldReset,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic               gameOver,
  output logic               winnerL
);

  localparam int CNT_MAX = (HOLD_CYCLES > RESTART_CYCLES) ? HOLD_CYCLES : RESTART_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, PLAY, OVER} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               prevL, prevR;
  logic               riseL, riseR;
  logic               ptL, ptR;
  logic [SCORE_W-1:0] incL, incR;

  assign riseL = keyL & ~prevL;
  assign riseR = keyR & ~prevR;
  // Simultaneous pulses are a no-move on the field, so they never score.
  assign ptL   = pressL & ~pressR & edgeL;
  assign ptR   = pressR & ~pressL & edgeR;
  assign incL  = scoreL + SCORE_W'(1);
  assign incR  = scoreR + SCORE_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      cnt        <= HOLD_LD;
      prevL      <= 1'b1;
      prevR      <= 1'b1;
      pressL     <= 1'b0;
      pressR     <= 1'b0;
      fieldReset <= 1'b1;
      scoreL     <= '0;
      scoreR     <= '0;
      gameOver   <= 1'b0;
      winnerL    <= 1'b0;
    end else begin
      prevL  <= keyL;
      prevR  <= keyR;
      pressL <= 1'b0;
      pressR <= 1'b0;
      case (state)
        HOLD: begin
          if (cnt == '0) begin
            state      <= PLAY;
            fieldReset <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PLAY: begin
          // Pulses only issue while play continues; a scoring edge freezes the field.
          if (ptL) begin
            scoreL <= incL;
            if (incL == WIN) begin
              state    <= OVER;
              gameOver <= 1'b1;
              winnerL  <= 1'b1;
`ifdef TUG_AUTO_RESTART_EN
              cnt      <= CNT_W'(RESTART_CYCLES - 1);
`endif
            end else begin
              state      <= HOLD;
              cnt        <= HOLD_LD;
              fieldReset <= 1'b1;
            end
          end else if (ptR) begin
            scoreR <= incR;
            if (incR == WIN) begin
              state    <= OVER;
              gameOver <= 1'b1;
              winnerL  <= 1'b0;
`ifdef TUG_AUTO_RESTART_EN
              cnt      <= CNT_W'(RESTART_CYCLES - 1);
`endif
            end else begin
              state      <= HOLD;
              cnt        <= HOLD_LD;
              fieldReset <= 1'b1;
            end
          end else begin
            pressL <= riseL;
            pressR <= riseR;
          end
        end
        OVER: begin
`ifdef TUG_AUTO_RESTART_EN
          if (cnt == '0) begin
            state      <= HOLD;
            cnt        <= HOLD_LD;
            fieldReset <= 1'b1;
            scoreL     <= '0;
            scoreR     <= '0;
            gameOver   <= 1'b0;
            winnerL    <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
`endif
        end
        default: begin
          state      <= HOLD;
          cnt        <= HOLD_LD;
          fieldReset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee: a match-level reference model checked every cycle,
// plus hand-computed literal checks on hold length, pulse timing and final scores.
module tb_tug_referee;

  localparam int WIN     = 7;
  localparam int HOLD    = 4;
  localparam int RESTART = 16;

  logic       clk = 1'b0;
  logic       reset, keyL, keyR, edgeL, edgeR;
  logic       pressL, pressR, fieldReset, gameOver, winnerL;
  logic [2:0] scoreL, scoreR;

  int n_cmp = 0;
  int n_bad = 0;

  tug_referee #(.WIN_SCORE(WIN), .SCORE_W(3), .HOLD_CYCLES(HOLD), .RESTART_CYCLES(RESTART)) dut (
    .clk(clk), .reset(reset), .keyL(keyL), .keyR(keyR), .edgeL(edgeL), .edgeR(edgeR),
    .pressL(pressL), .pressR(pressR), .fieldReset(fieldReset),
    .scoreL(scoreL), .scoreR(scoreR), .gameOver(gameOver), .winnerL(winnerL)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: hold time left, match scores, previous key levels, expected pulses.
  int m_sl = 0, m_sr = 0, m_hold = HOLD, m_left = 0;
  bit m_over = 0, m_win = 0, m_pl = 0, m_pr = 0, m_kl = 1, m_kr = 1;
  bit m_play, m_ptl, m_ptr;

  always_comb begin
    m_play = !m_over && (m_hold == 0);
    m_ptl  = m_play && m_pl && !m_pr && edgeL;
    m_ptr  = m_play && m_pr && !m_pl && edgeR;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sl <= 0; m_sr <= 0; m_hold <= HOLD; m_left <= 0;
      m_over <= 0; m_win <= 0; m_pl <= 0; m_pr <= 0; m_kl <= 1; m_kr <= 1;
    end else begin
      m_kl <= keyL;
      m_kr <= keyR;
      m_pl <= m_play && !m_ptl && !m_ptr && keyL && !m_kl;
      m_pr <= m_play && !m_ptl && !m_ptr && keyR && !m_kr;
      if (m_hold > 0) m_hold <= m_hold - 1;
      if (m_ptl) begin
        m_sl <= m_sl + 1;
        if (m_sl + 1 == WIN) begin m_over <= 1; m_win <= 1; m_left <= RESTART; end
        else m_hold <= HOLD;
      end else if (m_ptr) begin
        m_sr <= m_sr + 1;
        if (m_sr + 1 == WIN) begin m_over <= 1; m_win <= 0; m_left <= RESTART; end
        else m_hold <= HOLD;
      end else if (m_over) begin
`ifdef TUG_AUTO_RESTART_EN
        if (m_left == 1) begin
          m_over <= 0; m_win <= 0; m_sl <= 0; m_sr <= 0; m_hold <= HOLD;
        end else begin
          m_left <= m_left - 1;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    check("pressL", pressL, m_pl);
    check("pressR", pressR, m_pr);
    check("fieldReset", fieldReset, m_hold > 0);
    check("scoreL", scoreL, m_sl);
    check("scoreR", scoreR, m_sr);
    check("gameOver", gameOver, m_over);
    if (m_over) check("winnerL", winnerL, m_win);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int hi, pulses, first;
    reset = 1; keyL = 1; keyR = 1; edgeL = 0; edgeR = 0;
    tick(3);

    // Release with both keys held: 4-cycle hold, no pulses.
    reset = 0;
    hi = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      hi += fieldReset;
      pulses += pressL + pressR;
    end
    check("hold_len_after_reset", hi, 4);
    check("no_pulse_held_keys", pulses, 0);
    tick(1);
    keyL = 0; keyR = 0;
    tick(2);

    // Left key held 10 cycles: one pulse, on the 2nd sampled cycle.
    keyL = 1;
    pulses = 0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (pressL) begin pulses++; if (first == 0) first = i; end
    end
    check("held_key_pulses", pulses, 1);
    check("pulse_latency", first, 2);
    tick(1);
    keyL = 0;
    tick(2);

    // Simultaneous rise with edgeL lit: both pulses, no point.
    edgeL = 1; keyL = 1; keyR = 1;
    tick(1);
    check("both_pulse_L", pressL, 1);
    check("both_pulse_R", pressR, 1);
    tick(2);
    check("both_no_scoreL", scoreL, 0);
    check("both_no_hold", fieldReset, 0);
    keyL = 0; keyR = 0; edgeL = 0;
    tick(2);

    // Right point, then key chatter during the hold.
    edgeR = 1; keyR = 1;
    tick(2);
    check("right_point_score", scoreR, 1);
    check("right_point_hold", fieldReset, 1);
    keyL = 1; tick(1); keyL = 0; tick(1); keyL = 1; tick(1); keyL = 0;
    keyR = 0; edgeR = 0;
    tick(4);

    // Left wins the match.
    edgeL = 1;
    for (int p = 0; p < WIN; p++) begin
      keyL = 1; tick(1); keyL = 0; tick(6);
    end
    check("left_final_score", scoreL, 7);
    check("left_gameOver", gameOver, 1);
    check("left_winnerL", winnerL, 1);
    keyL = 1; tick(1); keyL = 0; tick(1);
    check("over_frozen_score", scoreL, 7);

    // Asynchronous reset mid-OVER.
    reset = 1;
    #1;
    check("async_scoreL", scoreL, 0);
    check("async_gameOver", gameOver, 0);
    check("async_fieldReset", fieldReset, 1);
    edgeL = 0;
    tick(2);
    reset = 0;
    tick(6);

    // Right wins; time the game-over display.
    edgeR = 1;
    for (int p = 0; p < WIN; p++) begin
      keyR = 1; tick(1); keyR = 0;
      if (p < WIN - 1) tick(6);
    end
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      hi += gameOver;
      if (i == 2) begin
        check("right_winnerL", winnerL, 0);
        check("right_final_score", scoreR, 7);
      end
    end
`ifdef TUG_AUTO_RESTART_EN
    check("over_display_len", hi, 16);
`else
    check("over_display_len", hi, 29);
`endif
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tug_referee.md
# tug_referee

Round and match controller for the tug-of-war playfield built from the normal/center light cells. It turns raw key levels into single-cycle move pulses and detects a point when a pull goes past an edge light. It clears and recenters the playfield between points, keeps both players' scores, and declares a winner. It sits between the synchronized key inputs and the playfield's `L`/`R`/`reset` inputs.

## Interface
- `WIN_SCORE`, default 7: points needed to win the match; 1 ≤ WIN_SCORE ≤ 2^SCORE_W − 1.
- `SCORE_W`, default 3: width of each score counter.
- `HOLD_CYCLES`, default 4: number of cycles `fieldReset` stays high after reset release and after each point; must be ≥ 1.
- `RESTART_CYCLES`, default 16: length of the game-over display before an automatic restart. Used only with `TUG_AUTO_RESTART_EN`.

- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `keyL` in 1: synchronized level, high while the left key is held.
- `keyR` in 1: synchronized level, high while the right key is held.
- `edgeL` in 1: the playfield's leftmost light is lit.
- `edgeR` in 1: the playfield's rightmost light is lit.
- `pressL` out 1: registered one-cycle move-left pulse to the playfield `L` input.
- `pressR` out 1: registered one-cycle move-right pulse to the playfield `R` input.
- `fieldReset` out 1: registered; drives playfield reset so only the center light is on.
- `scoreL` out SCORE_W: left player's score.
- `scoreR` out SCORE_W: right player's score.
- `gameOver` out 1: high once the match is decided.
- `winnerL` out 1: 1 = left won, 0 = right won; meaningful only while `gameOver` is high.

## Operation
- The FSM has three states: HOLD, PLAY and OVER. A down-counter `cnt` is shared by HOLD and OVER.
- Edge detect:
  - `prevL` and `prevR` register `keyL` and `keyR` every cycle, in every state.
  - A rising edge is `key & ~prev`.
  - In PLAY only, a rising edge loads `pressL`/`pressR` = 1 for the next cycle. Otherwise they load 0.
  - Rising edges seen in HOLD or OVER are discarded. A key held across HOLD→PLAY makes no pulse.
- Both pulses may be high in the same cycle; the playfield treats that as no move.
- HOLD:
  - `fieldReset` = 1; pulses are suppressed.
  - `cnt` decrements each cycle. When `cnt` = 0, go to PLAY.
- PLAY: `fieldReset` = 0. A point is scored on a clock edge where the pulse goes one way and the matching edge light is lit:
  - Left point: `pressL & ~pressR & edgeL`.
  - Right point: `pressR & ~pressL & edgeR`.
  - If the scorer's new score equals WIN_SCORE, the score is incremented, the state goes to OVER, `winnerL` is set, and `gameOver` = 1.
  - Otherwise the score is incremented, the state goes to HOLD, and `cnt` = HOLD_CYCLES−1.
  - Both edge conditions cannot both be true, because the pulses are mutually exclusive in the scoring terms. No point is scored if both pulses are high.
- OVER:
  - `fieldReset` = 0 and pulses are suppressed, so the final playfield picture is frozen.
  - Scores and `winnerL` hold.
- Scores never exceed WIN_SCORE, and there is no wrap.
- Reset, asserted at any time including mid-HOLD or OVER:
  - State = HOLD, `cnt` = HOLD_CYCLES−1.
  - Scores = 0; `pressL`/`pressR` = 0; `gameOver` = 0; `winnerL` = 0; `fieldReset` = 1.
  - `prevL`/`prevR` = 1, so a key held through reset makes no pulse.

## Timing
- Key rising edge sampled at edge N (in PLAY) → `pressL` high for cycle N+1 only → playfield moves at edge N+2.
- Score updates at the edge that consumes the pulse. `scoreL` shows the new value one cycle after the pulse, and `fieldReset` rises in that same cycle.
- `fieldReset` is high for exactly HOLD_CYCLES cycles: after reset deasserts, and after each non-winning point.
- The first pulse can appear at the earliest 2 cycles after HOLD exits, because the edge must be sampled in PLAY.
- `gameOver` rises one cycle after the winning pulse and stays high until reset (or until auto-restart).

## Configuration
- `TUG_AUTO_RESTART_EN` defined:
  - On entering OVER, `cnt` = RESTART_CYCLES−1.
  - When `cnt` reaches 0: scores clear, `gameOver` and `winnerL` clear, and the state goes to HOLD with `cnt` = HOLD_CYCLES−1.
- Not defined: OVER is terminal until `reset`, and RESTART_CYCLES is unused.

## Test plan
- Reset release with both keys held → `fieldReset` high for 4 cycles, then PLAY; no `pressL`/`pressR` until a key is released and pressed again.
- `keyL` held for 10 cycles in PLAY → exactly one `pressL` pulse, 1 cycle wide, 1 cycle after the rise.
- `keyL` and `keyR` rise in the same cycle with `edgeL` = 1 → both pulses high together; scores unchanged; state stays PLAY.
- `edgeR` = 1 and a right press → `scoreR` 0→1; `fieldReset` high for 4 cycles; key edges during the hold produce no pulses.
- Left scores 7 points → `scoreL` = 7, `gameOver` = 1, `winnerL` = 1; further presses produce no pulses and no score change. Assert `reset` mid-OVER → all outputs return to reset values immediately (asynchronously).
- With `TUG_AUTO_RESTART_EN`, a win by right → `gameOver` high for 16 cycles, then scores 0, `gameOver` = 0, and a 4-cycle `fieldReset`.
